// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
//   Shared constants and helpers for the BCD up/down counter.
//   - SEG_0..SEG_9, SEG_BLANK : active-low seven-segment codes {dp,g..a}.
//                               dp is always 1 (off).
//   - bcd_to_seg()            : one BCD digit to its segment code; any
//                               non-decimal nibble shows as blank.
//   - int_to_bcd()            : integer to packed BCD (up to 8 digits), used
//                               at elaboration to build constants such as the
//                               top count value MODULO-1.
// ----------------------------------------------------------------------------
package bcd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int MAX_DIGITS = 8;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Digits at or above 'digits' are left zero so the caller can slice the
  // low 4*digits bits without worrying about overflow into unused nibbles.
  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value,
                                                         input int digits);
    logic [4*MAX_DIGITS-1:0] bcd;
    int                      rem;
    bcd = '0;
    rem = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) bcd[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// ----------------------------------------------------------------------------
// bcd_seg_decode
//   Combinational seven-segment decoder for a single BCD digit.
//   Ports:
//     digit_i [3:0] : BCD digit to show
//     blank_i       : 1 forces all segments off
//     seg_o   [7:0] : active-low segments {dp,g..a}
// ----------------------------------------------------------------------------
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : bcd_to_seg(digit_i);

endmodule

// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter
//   N-digit BCD up/down counter with a tick prescaler and per-digit
//   seven-segment outputs. Single clock domain; the prescaler produces an
//   enable tick, never a derived clock.
//
//   Parameters:
//     DIGITS   : number of BCD digits (1..8)
//     MODULO   : count range 0..MODULO-1 (2..10**DIGITS)
//     TICK_DIV : clock cycles per count step (1 = step every enabled cycle)
//
//   Ports:
//     ck      : clock
//     rs_n    : asynchronous active-low reset
//     en      : count enable; prescaler and count hold when low
//     up      : 1 = increment, 0 = decrement
//     clr     : synchronous clear of count and prescaler (highest priority)
//     ld      : synchronous load of ld_val (invalid values load 0)
//     ld_val  : BCD load value, digit 0 in [3:0]
//     q       : registered BCD count, digit 0 in [3:0]
//     tick_o  : 1-cycle pulse when the prescaler expires
//     wrap_o  : 1-cycle pulse, coincident with the first wrapped value of q
//     hex     : active-low segments {dp,g..a} per digit, digit 0 in [7:0]
//
//   Build option:
//     LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//                             nonzero digit are blanked (digit 0 never is).
//                             q, tick_o and wrap_o are unaffected.
// ----------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int MODULO   = 30,
  parameter int TICK_DIV = 15000000
) (
  input  logic                ck,
  input  logic                rs_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] ld_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tick_o,
  output logic                wrap_o,
  output logic [8*DIGITS-1:0] hex
);

  localparam int W  = 4 * DIGITS;
  // A 1-bit prescaler is kept for TICK_DIV=1; it simply never leaves 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]           PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [4*MAX_DIGITS-1:0] TOP_BCD_ALL = int_to_bcd(MODULO - 1, DIGITS);
  localparam logic [W-1:0]            TOP_BCD     = TOP_BCD_ALL[W-1:0];

  logic [PW-1:0]     presc_q, presc_d;
  logic [W-1:0]      count_q, count_d;
  logic              wrap_q, wrap_d;

  logic              tick;
  logic              ld_ok;
  logic [W-1:0]      inc_val, dec_val;
  logic              inc_carry, dec_borrow;
  logic [DIGITS-1:0] blank;

  // Expiry is combinational so the step lands on the edge right after the
  // tick; gating with en means a held prescaler at PRESC_MAX keeps its
  // pending expiry until counting resumes.
  assign tick = en && (presc_q == PRESC_MAX);

  // Ripple BCD increment/decrement. Used only when q is not at the wrap
  // boundary, so the carry/borrow out of the top digit is never needed.
  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    inc_val   = count_q;
    dec_val   = count_q;
    inc_carry = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // With every digit decimal, BCD order equals numeric order, so a plain
  // magnitude compare against MODULO-1 in BCD is a valid range check.
  always_comb begin
    ld_ok = (ld_val <= TOP_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (ld_val[4*i +: 4] > 4'd9) ld_ok = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;

    if (en) presc_d = tick ? '0 : presc_q + 1'b1;

    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (ld) begin
      count_d = ld_ok ? ld_val : '0;
    end else if (tick) begin
      if (up) begin
        if (count_q == TOP_BCD) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (count_q == '0) begin
          count_d = TOP_BCD;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q      = count_q;
  assign tick_o = tick;
  assign wrap_o = wrap_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is blanked while every digit at or
  // above it is zero. Digit 0 is excluded so zero still shows as "0".
  logic zero_above;
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_seg_decode u_seg (
      .digit_i (count_q[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (hex[8*g +: 8])
    );
  end

endmodule
